z80_io_master: RTL and testbench
================================

// Module: z80_io_master
// PURPOSE
//  Initiator side of the Z80 I/O port bus: turns single-word port read/write requests from the CPU core
//  into IORQ_L/RD_L/WR_L bus cycles (T1, T2, TW..., T3) toward the port responders.
//  Drives address and write data, inserts automatic and WAIT_L-extended wait states, returns read data.
//  One transaction in flight; sits between core execute logic and the shared address/data bus.
// PARAMETERS
//  AUTO_WAIT  1   automatic TW states after T2 (>=1); responders return read data one clock after strobe
//  TIMEOUT    16  max extra WAIT_L-held TW cycles before abort (only with IO_TIMEOUT_EN)
// PORTS
//  clk        in   1   clock; all state changes on posedge
//  rst        in   1   synchronous reset, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   block can accept; high only in IO_IDLE
//  req_wr     in   1   1 = OUT (write), 0 = IN (read)
//  req_addr   in   16  port address; full 16 bits driven, responders decode [7:0]
//  req_wdata  in   8   write data
//  rsp_valid  out  1   one-cycle pulse: transaction complete
//  rsp_rdata  out  8   read data, valid with rsp_valid (8'h00 after writes)
//  rsp_err    out  1   timeout abort flag, valid with rsp_valid
//  IORQ_L     out  1   I/O request strobe, active-low
//  RD_L       out  1   read strobe, active-low
//  WR_L       out  1   write strobe, active-low
//  WAIT_L     in   1   responder wait request, active-low, synchronous to clk
//  addr_out   out  16  address bus drive value;  addr_oe  out 1  address bus enable
//  data_out   out  8   write data drive value;  data_oe  out 1  data bus enable (writes only)
//  data_in    in   8   read data from bus
// BEHAVIOUR
//  Reset (and any cycle with rst high, mid-transaction included): state IO_IDLE; IORQ_L=RD_L=WR_L=1;
//   addr_oe=data_oe=0; addr_out=0; data_out=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; req_ready=1 after reset.
//   In-flight transaction discarded, no rsp_valid.
//  Accept: req_valid & req_ready at posedge latches req_* and moves IO_IDLE -> IO_T1. req_* ignored otherwise.
//  IO_T1 (1 clk): addr_oe=1, addr_out=latched addr; write: data_oe=1, data_out=wdata. Strobes high.
//  IO_T2 (1 clk): IORQ_L=0 and RD_L=0 (read) or WR_L=0 (write). Address/data held.
//  IO_TW: first AUTO_WAIT cycles unconditional (WAIT_L ignored). At posedge ending last auto TW,
//   WAIT_L=0 -> stay in TW (extra wait); WAIT_L=1 -> IO_T3. Strobes, address, data held throughout.
//  IO_T3 (1 clk): strobes still asserted. At posedge ending T3: rsp_rdata<=data_in (read) or 8'h00 (write);
//   strobes high, addr_oe/data_oe=0, rsp_valid=1 for exactly one cycle, -> IO_IDLE.
//  WAIT_L ignored in IO_IDLE, T1, T2, T3.
//  Latency accept -> rsp_valid: 3 + AUTO_WAIT + extra-wait clocks (AUTO_WAIT=1, no waits: 4).
//  Back-to-back: new request may be accepted in the cycle rsp_valid is high (IO_IDLE); zero idle gap.
//  Strobes glitch-free: all strobe/enable outputs registered; RD_L and WR_L never low together.
// CONFIGURATION
//  IO_TIMEOUT_EN defined: extra-wait counter; when extra waits reach TIMEOUT, -> IO_T3 regardless of WAIT_L;
//   completion then has rsp_err=1, rsp_rdata=8'hFF. Counter cleared on each accept.
//  Not defined: waits unbounded; rsp_err tied 0; TIMEOUT unused. Port list identical both ways.
// STRUCTURE
//  Package z80_io_pkg: io_state_t enum {IO_IDLE, IO_T1, IO_T2, IO_TW, IO_T3}; IO_RD_ERR_DATA=8'hFF;
//   io_req_t struct {wr, addr[15:0], wdata[7:0]} shared with core execute stage.
//  Sub-module io_wait_counter: load/decrement counter for auto waits, plus timeout count under IO_TIMEOUT_EN.
// TESTING
//  Read 16'h0042, AUTO_WAIT=1, WAIT_L=1, responder holds reset default -> strobes low 3 clks, rsp 8'h42 at +4.
//  Write 8'hA5 to 16'h0010, then read 16'h0010 back-to-back -> WR_L then RD_L cycles, rsp_rdata=8'hA5, no gap.
//  WAIT_L low 5 clks after last auto TW on read -> T3 delayed exactly 5 clks, data sampled at T3 end.
//  rst high during T2 of a write -> next cycle all strobes high, oe low, no rsp_valid; next request normal.
//  IO_TIMEOUT_EN, TIMEOUT=16, WAIT_L stuck low -> rsp_valid after 16 extra waits, rsp_err=1, rdata=8'hFF.
//  Random req_valid toggling while busy -> req_ready low, requests not latched, RD_L&WR_L never both low.

Source files
------------

// File: rtl/z80_io_pkg.sv
// ----------------------------------------------------------------------------
// z80_io_pkg
// Shared types and constants for the Z80 I/O port bus initiator.
//   io_state_t     : bus-cycle phase (IO_IDLE, IO_T1, IO_T2, IO_TW, IO_T3)
//   io_req_t       : single-word port request, also used by the core execute stage
//   IO_RD_ERR_DATA : read data returned when a cycle is aborted by timeout
//   IO_CNT_W       : width of the automatic wait-state counter
// ----------------------------------------------------------------------------
package z80_io_pkg;

    typedef enum logic [2:0] {
        IO_IDLE,
        IO_T1,
        IO_T2,
        IO_TW,
        IO_T3
    } io_state_t;

    typedef struct packed {
        logic        wr;     // 1 = OUT, 0 = IN
        logic [15:0] addr;
        logic [7:0]  wdata;
    } io_req_t;

    localparam logic [7:0] IO_RD_ERR_DATA = 8'hFF;
    localparam int         IO_CNT_W       = 8;

endpackage

// File: rtl/io_wait_counter.sv
// ----------------------------------------------------------------------------
// io_wait_counter
// Wait-state bookkeeping for z80_io_master.
//   Auto-wait counter: loaded with AUTO_WAIT-1 on the T2->TW transition and
//   decremented each TW cycle; o_auto_done flags the last automatic TW.
//   Extra-wait counter (only when IO_TIMEOUT_EN is defined): cleared on each
//   accepted request, counts WAIT_L-extended TW cycles; o_timeout is high once
//   TIMEOUT extra waits have elapsed. Without the macro o_timeout is 0.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   i_load      : load auto counter (cycle is IO_T2)
//   i_dec       : decrement auto counter (cycle is IO_TW)
//   i_clr       : clear extra-wait counter (request accepted)
//   i_ext_inc   : one more extra wait is being entered
//   o_auto_done : automatic waits exhausted
//   o_timeout   : extra-wait budget exhausted
// ----------------------------------------------------------------------------
module io_wait_counter
    import z80_io_pkg::*;
#(
    parameter int AUTO_WAIT = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    input  logic i_clr,
    input  logic i_ext_inc,
    output logic o_auto_done,
    output logic o_timeout
);

    logic [IO_CNT_W-1:0] r_auto_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_auto_cnt <= '0;
        end else if (i_load) begin
            r_auto_cnt <= IO_CNT_W'(AUTO_WAIT - 1);
        end else if (i_dec && !o_auto_done) begin
            r_auto_cnt <= r_auto_cnt - IO_CNT_W'(1);
        end
    end

    assign o_auto_done = (r_auto_cnt == '0);

`ifdef IO_TIMEOUT_EN
    localparam int EXT_W = $clog2(TIMEOUT + 1);

    logic [EXT_W-1:0] r_ext_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ext_cnt <= '0;
        end else if (i_ext_inc) begin
            r_ext_cnt <= r_ext_cnt + EXT_W'(1);
        end
    end

    assign o_timeout = (r_ext_cnt == EXT_W'(TIMEOUT));
`else
    // Timeout hardware absent: inputs and TIMEOUT intentionally unused.
    logic w_unused;
    assign w_unused  = i_clr ^ i_ext_inc ^ (TIMEOUT == 0);
    assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/z80_io_master.sv
// ----------------------------------------------------------------------------
// z80_io_master
// Initiator side of the Z80 I/O port bus. Turns one port read/write request at
// a time into an IORQ_L/RD_L/WR_L bus cycle T1, T2, TW..., T3 and returns the
// result as a one-cycle rsp_valid pulse. Every strobe and enable is a flop.
// Optional feature macro: IO_TIMEOUT_EN (abort after TIMEOUT extra waits,
// completing with rsp_err=1 and rsp_rdata=8'hFF).
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only in IO_IDLE)
//   req_wr/req_addr/req_wdata  : request contents (1 = OUT, 0 = IN)
//   rsp_valid/rsp_rdata/rsp_err: completion pulse, read data, timeout flag
//   IORQ_L/RD_L/WR_L           : active-low bus strobes
//   WAIT_L                     : responder wait request, active-low
//   addr_out/addr_oe           : address bus value and enable
//   data_out/data_oe           : write data value and enable (writes only)
//   data_in                    : read data from the bus
// ----------------------------------------------------------------------------
module z80_io_master
    import z80_io_pkg::*;
#(
    parameter int AUTO_WAIT = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        IORQ_L,
    output logic        RD_L,
    output logic        WR_L,
    input  logic        WAIT_L,
    output logic [15:0] addr_out,
    output logic        addr_oe,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in
);

    io_state_t  r_state;
    io_req_t    r_req;
    logic       r_req_ready;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
    logic       r_rsp_err;
    logic       r_err_pend;
    logic       r_iorq_l;
    logic       r_rd_l;
    logic       r_wr_l;
    logic       r_addr_oe;
    logic       r_data_oe;

    io_req_t    w_req;
    logic       w_accept;
    logic       w_auto_done;
    logic       w_timeout;
    logic       w_extra_wait;

    assign w_req    = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
    assign w_accept = (r_state == IO_IDLE) && req_valid;

    // Staying in TW past the automatic waits because the responder still
    // holds WAIT_L low and the timeout budget (if any) is not yet spent.
    assign w_extra_wait = (r_state == IO_TW) && w_auto_done && !WAIT_L && !w_timeout;

    io_wait_counter #(
        .AUTO_WAIT (AUTO_WAIT),
        .TIMEOUT   (TIMEOUT)
    ) u_wait_counter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (r_state == IO_T2),
        .i_dec       (r_state == IO_TW),
        .i_clr       (w_accept),
        .i_ext_inc   (w_extra_wait),
        .o_auto_done (w_auto_done),
        .o_timeout   (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IO_IDLE;
            r_req       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= 1'b0;
            r_err_pend  <= 1'b0;
            r_iorq_l    <= 1'b1;
            r_rd_l      <= 1'b1;
            r_wr_l      <= 1'b1;
            r_addr_oe   <= 1'b0;
            r_data_oe   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IO_IDLE: begin
                    if (w_accept) begin
                        r_state     <= IO_T1;
                        r_req       <= w_req;
                        r_req_ready <= 1'b0;
                        r_err_pend  <= 1'b0;
                        r_addr_oe   <= 1'b1;
                        r_data_oe   <= req_wr;
                    end
                end
                IO_T1: begin
                    r_state  <= IO_T2;
                    r_iorq_l <= 1'b0;
                    r_rd_l   <= r_req.wr;
                    r_wr_l   <= ~r_req.wr;
                end
                IO_T2: begin
                    r_state <= IO_TW;
                end
                IO_TW: begin
                    // WAIT_L only matters once the automatic waits are spent.
                    if (w_auto_done) begin
                        if (WAIT_L) begin
                            r_state <= IO_T3;
                        end else if (w_timeout) begin
                            r_state    <= IO_T3;
                            r_err_pend <= 1'b1;
                        end
                    end
                end
                IO_T3: begin
                    r_state     <= IO_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= r_err_pend;
                    r_rsp_rdata <= r_err_pend ? IO_RD_ERR_DATA :
                                   (r_req.wr ? 8'h00 : data_in);
                    r_iorq_l    <= 1'b1;
                    r_rd_l      <= 1'b1;
                    r_wr_l      <= 1'b1;
                    r_addr_oe   <= 1'b0;
                    r_data_oe   <= 1'b0;
                end
                default: begin
                    r_state <= IO_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign IORQ_L    = r_iorq_l;
    assign RD_L      = r_rd_l;
    assign WR_L      = r_wr_l;
    assign addr_out  = r_req.addr;
    assign addr_oe   = r_addr_oe;
    assign data_out  = r_req.wdata;
    assign data_oe   = r_data_oe;

endmodule

// File: tb/tb_z80_io_master.sv
// ----------------------------------------------------------------------------
// tb_z80_io_master
// Self-checking bench for z80_io_master. A transaction-level model knows, for
// the request in flight, how many clocks after acceptance each bus phase lasts
// (T1 one clock, strobes low for 2+AUTO_WAIT+extra clocks, response after
// 3+AUTO_WAIT+extra) and what data must come back. A negedge process compares
// every DUT output against that model each cycle; directed tests add literal
// expectations for data, latency and strobe length. A simple port responder
// (256-byte memory, data valid one clock after RD_L falls and only while
// WAIT_L is high) sits on the bus.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_z80_io_master;

    localparam int AW = 1;
    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        IORQ_L;
    logic        RD_L;
    logic        WR_L;
    logic        WAIT_L;
    logic [15:0] addr_out;
    logic        addr_oe;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;

    z80_io_master #(
        .AUTO_WAIT (AW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .IORQ_L    (IORQ_L),
        .RD_L      (RD_L),
        .WR_L      (WR_L),
        .WAIT_L    (WAIT_L),
        .addr_out  (addr_out),
        .addr_oe   (addr_oe),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .data_in   (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- port responder ----------------
    logic [7:0] resp_mem [256];
    logic       rd_seen;

    initial rd_seen = 1'b0;
    always @(posedge clk) begin
        rd_seen <= !IORQ_L && !RD_L;
        if (!IORQ_L && !WR_L && data_oe) resp_mem[addr_out[7:0]] <= data_out;
    end
    assign data_in = (rd_seen && !IORQ_L && !RD_L && WAIT_L) ? resp_mem[addr_out[7:0]] : 8'hEE;

    // ---------------- model state ----------------
    logic [7:0]  model_mem [256];
    bit          m_busy;
    bit          m_after_rst;
    int          m_k;
    int          m_total;
    int          m_n;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_exp_rdata;
    logic        m_exp_err;

    bit          acc_pending;
    logic        p_wr;
    logic [15:0] p_addr;
    logic [7:0]  p_wdata;
    int          p_n;

    int cyc;
    int last_acc_cyc;
    int last_rsp_cyc;
    int rd_low_cnt;
    int n_checks;
    int n_errors;
    bit chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one clock and move the model to the window after that edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_busy      = 1'b0;
            m_after_rst = 1'b1;
            acc_pending = 1'b0;
        end else begin
            if (m_busy && m_k == m_total) begin
                if (m_wr) model_mem[m_addr[7:0]] = m_wdata;
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_k++;
            end
            if (acc_pending) begin
                acc_pending = 1'b0;
                m_busy      = 1'b1;
                m_after_rst = 1'b0;
                m_k         = 0;
                m_wr        = p_wr;
                m_addr      = p_addr;
                m_wdata     = p_wdata;
                m_n         = p_n;
                m_exp_err   = 1'b0;
`ifdef IO_TIMEOUT_EN
                if (p_n > TO) begin
                    m_n       = TO;
                    m_exp_err = 1'b1;
                end
`endif
                m_total      = 3 + AW + m_n;
                m_exp_rdata  = m_exp_err ? 8'hFF : (p_wr ? 8'h00 : model_mem[p_addr[7:0]]);
                last_acc_cyc = cyc;
                last_rsp_cyc = -1;
                rd_low_cnt   = 0;
            end
        end
        if (rsp_valid && last_rsp_cyc < 0) last_rsp_cyc = cyc;
        if (!RD_L) rd_low_cnt++;
    endtask

    // One transaction: n = extra waits requested by the responder, noise =
    // toggle req_* while busy and pulse WAIT_L in T1/T2, rst_k = window in
    // which reset is asserted (-1 = none). Returns in the response window.
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                           input int n, input bit noise, input int rst_k);
        req_valid   = 1'b1;
        req_wr      = wr;
        req_addr    = addr;
        req_wdata   = wdata;
        p_wr        = wr;
        p_addr      = addr;
        p_wdata     = wdata;
        p_n         = n;
        acc_pending = 1'b1;
        step();
        req_valid = 1'b0;
        while (m_busy && m_k < m_total) begin
            WAIT_L = !((m_k >= 1 + AW && m_k <= AW + m_n) || (noise && m_k <= 1));
            if (noise) begin
                req_valid = 1'($urandom_range(0, 1));
                req_wr    = 1'($urandom_range(0, 1));
                req_addr  = 16'($urandom);
                req_wdata = 8'($urandom);
            end
            if (m_k == rst_k) rst = 1'b1;
            step();
            if (rst) begin
                rst = 1'b0;
                break;
            end
        end
        WAIT_L    = 1'b1;
        req_valid = 1'b0;
    endtask

    // ---------------- per-cycle compare against the model ----------------
    bit e_busy;
    bit e_low;
    bit e_rsp;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = m_busy && (m_k < m_total);
            e_low  = e_busy && (m_k >= 1);
            e_rsp  = m_busy && (m_k == m_total);
            check("req_ready", req_ready, !e_busy);
            check("IORQ_L", IORQ_L, !e_low);
            check("RD_L", RD_L, !(e_low && !m_wr));
            check("WR_L", WR_L, !(e_low && m_wr));
            check("addr_oe", addr_oe, e_busy);
            check("data_oe", data_oe, e_busy && m_wr);
            check("rsp_valid", rsp_valid, e_rsp);
            check("rd_wr_exclusive", RD_L | WR_L, 1);
            if (e_busy) check("addr_out", addr_out, m_addr);
            if (e_busy && m_wr) check("data_out", data_out, m_wdata);
            if (e_rsp) begin
                check("rsp_rdata", rsp_rdata, m_exp_rdata);
                check("rsp_err", rsp_err, m_exp_err);
            end
            if (m_after_rst && !m_busy) begin
                check("rst_addr_out", addr_out, 0);
                check("rst_data_out", data_out, 0);
                check("rst_rsp_rdata", rsp_rdata, 0);
                check("rst_rsp_err", rsp_err, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    int w_rsp;

    initial begin
        for (int i = 0; i < 256; i++) begin
            resp_mem[i]  = 8'(i);
            model_mem[i] = 8'(i);
        end
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
        WAIT_L = 1'b1;
        m_busy = 1'b0; m_after_rst = 1'b1; acc_pending = 1'b0;
        m_k = 0; m_total = 0; m_n = 0; m_wr = 1'b0; m_addr = 16'h0; m_wdata = 8'h0;
        m_exp_rdata = 8'h0; m_exp_err = 1'b0;
        cyc = 0; last_acc_cyc = 0; last_rsp_cyc = -1; rd_low_cnt = 0;
        n_checks = 0; n_errors = 0; chk_en = 1'b0;

        step();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_req_ready", req_ready, 1);
        check("reset_strobes", {IORQ_L, RD_L, WR_L}, 3'b111);

        // Plain read of the responder's default contents.
        run_txn(1'b0, 16'h0042, 8'h00, 0, 1'b0, -1);
        check("read42_rdata", rsp_rdata, 8'h42);
        check("read42_latency", last_rsp_cyc - last_acc_cyc, 4);
        check("read42_rd_low_clks", rd_low_cnt, 3);
        step();

        // Write then read back with zero idle gap.
        run_txn(1'b1, 16'h0010, 8'hA5, 0, 1'b0, -1);
        w_rsp = last_rsp_cyc;
        check("write10_rdata", rsp_rdata, 8'h00);
        run_txn(1'b0, 16'h0010, 8'h00, 0, 1'b0, -1);
        check("b2b_gap", last_acc_cyc - w_rsp, 1);
        check("b2b_rdata", rsp_rdata, 8'hA5);
        step();

        // Five responder-requested extra waits.
        run_txn(1'b0, 16'h0077, 8'h00, 5, 1'b0, -1);
        check("wait5_latency", last_rsp_cyc - last_acc_cyc, 9);
        check("wait5_rdata", rsp_rdata, 8'h77);
        step();

        // Reset during T2 of a write, then a normal read.
        run_txn(1'b1, 16'h0030, 8'h3C, 0, 1'b0, 1);
        step();
        step();
        check("rst_abort_no_rsp", last_rsp_cyc, -1);
        run_txn(1'b0, 16'h0020, 8'h00, 0, 1'b0, -1);
        check("after_rst_rdata", rsp_rdata, 8'h20);
        check("after_rst_latency", last_rsp_cyc - last_acc_cyc, 4);
        step();

        // Request noise and ignored WAIT_L pulses while busy.
        run_txn(1'b1, 16'h0055, 8'h5A, 2, 1'b1, -1);
        run_txn(1'b0, 16'h0055, 8'h00, 0, 1'b1, -1);
        check("noise_rdata", rsp_rdata, 8'h5A);
        step();

        // Exactly TIMEOUT extra waits completes normally in both builds.
        run_txn(1'b0, 16'h0001, 8'h00, 16, 1'b0, -1);
        check("wait16_latency", last_rsp_cyc - last_acc_cyc, 20);
        check("wait16_rdata", rsp_rdata, 8'h01);
        check("wait16_err", rsp_err, 0);
        step();

`ifdef IO_TIMEOUT_EN
        // WAIT_L stuck low: abort after TIMEOUT extra waits.
        run_txn(1'b0, 16'h0002, 8'h00, 100, 1'b0, -1);
        check("timeout_latency", last_rsp_cyc - last_acc_cyc, 20);
        check("timeout_err", rsp_err, 1);
        check("timeout_rdata", rsp_rdata, 8'hFF);
`else
        // No timeout hardware: long waits are honoured.
        run_txn(1'b0, 16'h0002, 8'h00, 20, 1'b0, -1);
        check("wait20_latency", last_rsp_cyc - last_acc_cyc, 24);
        check("wait20_err", rsp_err, 0);
        check("wait20_rdata", rsp_rdata, 8'h02);
`endif
        step();

        run_txn(1'b0, 16'h0003, 8'h00, 3, 1'b0, -1);
        check("final_latency", last_rsp_cyc - last_acc_cyc, 7);
        check("final_rdata", rsp_rdata, 8'h03);
        check("final_err", rsp_err, 0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
